// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx : 8N1 UART serializer, LSB first, with a valid/ready byte input.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> an even-parity bit is sent between data bit 7 and the stop bit
//                (11-bit frame).
//   undefined -> plain 8N1 (10-bit frame); no parity state or logic.
//
// Parameters
//   CLK_FREQ  system clock in Hz
//   BAUD      line rate in bit/s
//   BAUD_CNT  clocks per bit (CLK_FREQ/BAUD, truncated)
//
// Ports
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   tx_data  byte to send, sampled only on the accept cycle
//   tx_vld   tx_data valid
//   tx_rdy   idle, a byte can be accepted (registered)
//   tx_uart  serial line, idle high (registered)
//   tx_done  one-cycle pulse on the last clock of the stop bit (registered)
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600,
    parameter int BAUD_CNT = CLK_FREQ / BAUD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_vld,
    output logic       tx_rdy,
    output logic       tx_uart,
    output logic       tx_done
);

    localparam int CNT_W = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BAUD_CNT - 1);
    // tx_done is registered, so it is raised one clock ahead of the bit end
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(BAUD_CNT - 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [2:0]       cnt1_q, cnt1_d;
    logic [7:0]       data_q, data_d;
    logic             tx_uart_q, tx_uart_d;
    logic             tx_rdy_q, tx_rdy_d;
    logic             tx_done_q, tx_done_d;
`ifdef UART_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    logic bit_end;
    assign bit_end = (cnt0_q == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt0_q    <= '0;
            cnt1_q    <= '0;
            data_q    <= '0;
            tx_uart_q <= 1'b1;
            tx_rdy_q  <= 1'b1;
            tx_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt0_q    <= cnt0_d;
            cnt1_q    <= cnt1_d;
            data_q    <= data_d;
            tx_uart_q <= tx_uart_d;
            tx_rdy_q  <= tx_rdy_d;
            tx_done_q <= tx_done_d;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt0_d    = bit_end ? '0 : cnt0_q + CNT_W'(1);
        cnt1_d    = cnt1_q;
        data_d    = data_q;
        tx_uart_d = tx_uart_q;
        tx_rdy_d  = 1'b0;
        tx_done_d = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            IDLE: begin
                cnt0_d    = '0;
                cnt1_d    = '0;
                tx_uart_d = 1'b1;
                tx_rdy_d  = 1'b1;
                if (tx_vld && tx_rdy_q) begin
                    state_d   = START;
                    data_d    = tx_data;
                    tx_uart_d = 1'b0;
                    tx_rdy_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_d     = ^tx_data;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    // data_q[0] always holds the next bit to drive
                    state_d   = DATA;
                    cnt1_d    = '0;
                    tx_uart_d = data_q[0];
                    data_d    = data_q >> 1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (cnt1_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
                        tx_uart_d = par_q;
`else
                        state_d   = STOP;
                        tx_uart_d = 1'b1;
`endif
                    end else begin
                        cnt1_d    = cnt1_q + 3'd1;
                        tx_uart_d = data_q[0];
                        data_d    = data_q >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d   = STOP;
                    tx_uart_d = 1'b1;
                end
            end
`endif
            STOP: begin
                tx_uart_d = 1'b1;
                tx_done_d = (cnt0_q == CNT_PRE);
                if (bit_end) begin
                    state_d  = IDLE;
                    tx_rdy_d = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                cnt0_d    = '0;
                tx_uart_d = 1'b1;
                tx_rdy_d  = 1'b1;
            end
        endcase
    end

    assign tx_uart = tx_uart_q;
    assign tx_rdy  = tx_rdy_q;
    assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

    // scaled baud so the whole run stays short: 160/10 = 16 clocks per bit
    localparam int B = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_vld = 1'b0;
    logic       tx_rdy, tx_uart, tx_done;

    uart_tx #(.CLK_FREQ(160), .BAUD(10)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_data (tx_data),
        .tx_vld  (tx_vld),
        .tx_rdy  (tx_rdy),
        .tx_uart (tx_uart),
        .tx_done (tx_done)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [7:0]    exp_q[$];
    logic [7:0]    e;
    logic [NB-1:0] bits;
    logic [NB-1:0] last_bits;
    logic          mon_busy = 1'b0;
    int            mc = 0;
    int            cyc = 0;
    int            end_cyc = -1000;
    int            last_gap = -1;
    int            frames = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            mon_busy = 1'b0;
        end else if (!mon_busy) begin
            if (tx_done) chk("done_while_idle", 1, 0);
            if (!tx_uart) begin
                mon_busy = 1'b1;
                mc       = 0;
                last_gap = cyc - end_cyc;
            end
        end
        if (rst_n && mon_busy) begin
            if ((mc % B) == B / 2 && (mc / B) < NB) begin
                bits[mc / B] = tx_uart;
                chk("rdy_low_in_frame", int'(tx_rdy), 0);
            end
            if (tx_done || mc == NB * B - 1)
                chk("done_cycle", tx_done ? mc : -1, NB * B - 1);
            if (mc == NB * B) begin
                chk("rdy_after_frame", int'(tx_rdy), 1);
                chk("line_after_frame", int'(tx_uart), 1);
                chk("start_bit", int'(bits[0]), 0);
                chk("stop_bit", int'(bits[NB-1]), 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("byte", int'(bits[8:1]), int'(e));
`ifdef UART_TX_PARITY_EN
                    chk("parity_bit", int'(bits[9]), int'(^e));
`endif
                end
                last_bits = bits;
                frames++;
                end_cyc  = cyc;
                mon_busy = 1'b0;
            end
            mc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_rdy();
        int n = 0;
        while (!tx_rdy && n < 3 * NB * B) begin
            @(negedge clk);
            n++;
        end
        if (!tx_rdy) chk("rdy_timeout", 0, 1);
    endtask

    task automatic wait_frames(input int n);
        int t = 0;
        while (frames < n && t < 3 * NB * B) begin
            @(negedge clk);
            t++;
        end
        chk("frames_seen", frames, n);
    endtask

    task automatic send(input logic [7:0] d, input bit push);
        @(negedge clk);
        wait_rdy();
        tx_data = d;
        tx_vld  = 1'b1;
        if (push) exp_q.push_back(d);
        chk("line_high_before_accept", int'(tx_uart), 1);
        @(negedge clk);
        tx_vld  = 1'b0;
        tx_data = ~d;
        chk("start_latency", int'(tx_uart), 0);
        chk("rdy_drop", int'(tx_rdy), 0);
    endtask

    task automatic idle_watch(input int n, input string name);
        int bad = 0;
        repeat (n) begin
            @(negedge clk);
            if (!tx_uart || !tx_rdy || tx_done) bad++;
        end
        chk(name, bad, 0);
    endtask

    initial begin
        #35;
        chk("rst_uart", int'(tx_uart), 1);
        chk("rst_rdy", int'(tx_rdy), 1);
        chk("rst_done", int'(tx_done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_watch(200, "idle_after_reset");

        // single frame 0x31
        send(8'h31, 1'b1);
        wait_frames(1);
`ifdef UART_TX_PARITY_EN
        chk("frame_31_bits", int'(last_bits), int'(11'b11001100010));
`else
        chk("frame_31_bits", int'(last_bits), int'(10'b1001100010));
`endif

        // back-to-back with tx_vld held high, data switched on tx_done
        @(negedge clk);
        wait_rdy();
        tx_data = 8'h55;
        tx_vld  = 1'b1;
        exp_q.push_back(8'h55);
        @(negedge clk);
        begin
            int t = 0;
            while (!tx_done && t < 2 * NB * B) begin
                @(negedge clk);
                t++;
            end
            chk("b2b_done_seen", int'(tx_done), 1);
        end
        tx_data = 8'hAA;
        exp_q.push_back(8'hAA);
        @(negedge clk);
        chk("b2b_rdy_after_done", int'(tx_rdy), 1);
        @(negedge clk);
        tx_vld = 1'b0;
        chk("b2b_second_start", int'(tx_uart), 0);
        wait_frames(3);
        chk("b2b_gap", last_gap, 1);

        // tx_vld mid-frame is ignored
        send(8'h00, 1'b1);
        repeat (3 * B) @(negedge clk);
        tx_data = 8'hFF;
        tx_vld  = 1'b1;
        @(negedge clk);
        tx_vld = 1'b0;
        chk("ignored_rdy_low", int'(tx_rdy), 0);
        wait_frames(4);
        idle_watch(NB * B + 20, "no_frame_from_ignored");
        chk("frames_after_ignored", frames, 4);

        // reset during data bit 3 of 0xA5 (bit 3 is 0)
        send(8'hA5, 1'b0);
        repeat (4 * B + B / 2) @(negedge clk);
        chk("bit3_before_reset", int'(tx_uart), 0);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_uart", int'(tx_uart), 1);
        chk("async_rst_rdy", int'(tx_rdy), 1);
        chk("async_rst_done", int'(tx_done), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_watch(3 * B, "idle_after_mid_reset");
        chk("frames_after_reset", frames, 4);

        send(8'h3C, 1'b1);
        wait_frames(5);
        chk("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
